// File: rtl/if_id_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The request is level-held; the ack is a one-cycle pulse carrying the read data.
interface if_id_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_id_fetch.sv
// IF/ID pipeline register with instruction-memory fetch control,
// a one-entry skid buffer for stalled returns and squashing of in-flight fetches.
//
// state | meaning
// FETCH | request outstanding (or about to issue), waiting for imem_ack
// BUF   | word returned while decode stalled, held in the skid buffer
// DROP  | squashed request still outstanding, waiting for its ack to discard
module if_id_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [31:0]          pc_F,
  output logic                 Stall_F,
  if_id_fetch_if.master        imem,
  input  logic                 Stall_D,
  input  logic                 Flush_D,
  output logic [31:0]          instr_D,
  output logic [31:0]          pc_D,
  output logic [31:0]          pc8_D,
  output logic                 valid_D
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_BUF   = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        req_q;
  logic        first_q;
  logic [31:0] addr_q;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        ack;
  logic [31:0] req_addr;

  // An ack is only meaningful while a request is actually on the bus.
  assign ack      = imem.imem_ack & req_q;
  assign req_addr = first_q ? pc_F : addr_q;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = req_addr;
  assign pc8_D          = pc_D + 32'd8;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (Flush_D) begin
          state_d = (ack || !req_q) ? S_FETCH : S_DROP;
        end else if (ack && Stall_D) begin
          state_d = S_BUF;
        end
      end
      S_BUF: begin
        if (Flush_D || !Stall_D) state_d = S_FETCH;
      end
      S_DROP: begin
        // A flush here keeps us waiting; only the ack retires the squashed request.
        if (ack) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    Stall_F = 1'b0;
    if (Reset) begin
      case (state_q)
        S_FETCH: Stall_F = !(Flush_D || (ack && !Stall_D));
        S_BUF:   Stall_F = Stall_D && !Flush_D;
        S_DROP:  Stall_F = !Flush_D;
        default: Stall_F = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_FETCH;
      req_q     <= 1'b0;
      first_q   <= 1'b0;
      addr_q    <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc    <= RESET_PC;
      instr_D   <= NOP_INSTR;
      pc_D      <= RESET_PC;
      valid_D   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d != S_BUF);
      // A new request starts whenever the next cycle requests and the current one is done.
      first_q <= (state_d != S_BUF) && (!req_q || ack);
      if (first_q) addr_q <= pc_F;

      if (Flush_D) begin
        instr_D <= NOP_INSTR;
        pc_D    <= RESET_PC;
        valid_D <= 1'b0;
      end else begin
        case (state_q)
          S_FETCH: begin
            if (ack && !Stall_D) begin
              instr_D <= imem.imem_rdata;
              pc_D    <= req_addr;
              valid_D <= 1'b1;
            end else if (ack) begin
              buf_instr <= imem.imem_rdata;
              buf_pc    <= req_addr;
            end else if (!Stall_D) begin
              instr_D <= NOP_INSTR;
              pc_D    <= RESET_PC;
              valid_D <= 1'b0;
            end
          end
          S_BUF: begin
            if (!Stall_D) begin
              instr_D <= buf_instr;
              pc_D    <= buf_pc;
              valid_D <= 1'b1;
            end
          end
          S_DROP: begin
            if (!Stall_D) begin
              instr_D <= NOP_INSTR;
              pc_D    <= RESET_PC;
              valid_D <= 1'b0;
            end
          end
          default: begin
            instr_D <= NOP_INSTR;
            pc_D    <= RESET_PC;
            valid_D <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
